// File: rtl/alu_seq64_pkg.sv
// Shared definitions for the 64-bit-over-32-bit ALU sequencer: opcodes, ALU control codes
// and the per-opcode ALU control selection.
package alu_seq64_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_ADC   = 3'b001,
    OP_SUB   = 3'b010,
    OP_OR    = 3'b011,
    OP_AND   = 3'b100,
    OP_NOTA  = 3'b101,
    OP_PASSA = 3'b110,
    OP_RSV   = 3'b111
  } op_e;

  localparam logic [3:0] ALUC_PASSA = 4'b0000;
  localparam logic [3:0] ALUC_NOTA  = 4'b0010;
  localparam logic [3:0] ALUC_NOTB  = 4'b0011;
  localparam logic [3:0] ALUC_ADD   = 4'b0100;
  localparam logic [3:0] ALUC_ADC   = 4'b0101;
  localparam logic [3:0] ALUC_OR    = 4'b0110;
  localparam logic [3:0] ALUC_AND   = 4'b0111;

  function automatic logic is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB);
  endfunction

  function automatic logic [3:0] lo_aluc(input op_e op);
    logic [3:0] c;
    case (op)
      OP_ADD:   c = ALUC_ADD;
      OP_ADC:   c = ALUC_ADC;
      OP_SUB:   c = ALUC_ADC;
      OP_OR:    c = ALUC_OR;
      OP_AND:   c = ALUC_AND;
      OP_NOTA:  c = ALUC_NOTA;
      default:  c = ALUC_PASSA;
    endcase
    return c;
  endfunction

  // The high word of every add chains the low-word carry, so it always uses ADC.
  function automatic logic [3:0] hi_aluc(input op_e op);
    return is_arith(op) ? ALUC_ADC : lo_aluc(op);
  endfunction

endpackage

// File: rtl/alu_seq64.sv
// Sequences 2W-bit operations through an external W-bit ALU, low word first,
// with subtract pre-inverting B through the ALU itself.
module alu_seq64
  import alu_seq64_pkg::*;
#(
  parameter int         W         = 32,
  parameter logic [3:0] IDLE_ALUC = 4'b1000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [2*W-1:0] opa,
  input  logic [2*W-1:0] opb,
  input  logic           cin,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           carry,
  output logic           ovf,
  output logic           err,
  output logic [W-1:0]   alu_ina,
  output logic [W-1:0]   alu_inb,
  output logic [3:0]     alu_aluc,
  output logic           alu_cin,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_cout,
  input  logic           alu_overflow
);

  // state | meaning
  // IDLE  | waiting for start, ALU idle-driven
  // NEGLO | ALU inverts B low word
  // NEGHI | ALU inverts B high word
  // LO    | low word through ALU
  // HI    | high word through ALU, carry chained
  // DONE  | done pulse, result/flags valid
  typedef enum logic [2:0] {
    S_IDLE, S_NEGLO, S_NEGHI, S_LO, S_HI, S_DONE
  } state_e;

  state_e         state;
  op_e            op_q;
  logic [2*W-1:0] a_q;
  logic [W-1:0]   b_lo;
  logic [W-1:0]   b_hi;
  logic [W-1:0]   res_lo;
  op_e            op_in;

  assign op_in = op_e'(op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_lo     <= '0;
      b_hi     <= '0;
      res_lo   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      err      <= 1'b0;
      alu_ina  <= '0;
      alu_inb  <= '0;
      alu_aluc <= IDLE_ALUC;
      alu_cin  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op_in;
            a_q  <= opa;
            b_lo <= opb[W-1:0];
            b_hi <= opb[2*W-1:W];
            err  <= 1'b0;
            busy <= 1'b1;
            if (op_in == OP_SUB) begin
              state    <= S_NEGLO;
              alu_ina  <= '0;
              alu_inb  <= opb[W-1:0];
              alu_aluc <= ALUC_NOTB;
              alu_cin  <= 1'b0;
            end else if (op_in == OP_RSV) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              carry <= 1'b0;
              ovf   <= 1'b0;
            end else begin
              state    <= S_LO;
              alu_ina  <= opa[W-1:0];
              alu_inb  <= opb[W-1:0];
              alu_aluc <= lo_aluc(op_in);
              alu_cin  <= (op_in == OP_ADC) ? cin : 1'b0;
            end
          end
        end
        S_NEGLO: begin
          b_lo    <= alu_out;
          alu_inb <= b_hi;
          state   <= S_NEGHI;
        end
        S_NEGHI: begin
          b_hi     <= alu_out;
          alu_ina  <= a_q[W-1:0];
          alu_inb  <= b_lo;
          alu_aluc <= ALUC_ADC;
          alu_cin  <= 1'b1;
          state    <= S_LO;
        end
        S_LO: begin
          // Low word is staged so the visible result only changes together with done.
          res_lo   <= alu_out;
          alu_ina  <= a_q[2*W-1:W];
          alu_inb  <= b_hi;
          alu_aluc <= hi_aluc(op_q);
          alu_cin  <= is_arith(op_q) ? alu_cout : 1'b0;
          state    <= S_HI;
        end
        S_HI: begin
          result   <= {alu_out, res_lo};
          carry    <= is_arith(op_q) ? alu_cout : 1'b0;
          ovf      <= is_arith(op_q) ? alu_overflow : 1'b0;
          done     <= 1'b1;
          alu_ina  <= '0;
          alu_inb  <= '0;
          alu_aluc <= IDLE_ALUC;
          alu_cin  <= 1'b0;
          state    <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          alu_ina  <= '0;
          alu_inb  <= '0;
          alu_aluc <= IDLE_ALUC;
          alu_cin  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq64.sv
// Self-checking bench for alu_seq64: a behavioural 32-bit ALU drives the DUT's ALU port,
// and results are checked against a 64-bit arithmetic reference model.
module tb_alu_seq64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [63:0] opa = '0;
  logic [63:0] opb = '0;
  logic        cin = 1'b0;
  logic        busy, done, carry, ovf, err;
  logic [63:0] result;
  logic [31:0] alu_ina, alu_inb, alu_out;
  logic [3:0]  alu_aluc;
  logic        alu_cin, alu_cout, alu_overflow;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_res = '0;

  always #5 clk = ~clk;

  alu_seq64 dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb), .cin(cin),
    .busy(busy), .done(done), .result(result), .carry(carry), .ovf(ovf), .err(err),
    .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_aluc(alu_aluc), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_overflow(alu_overflow)
  );

  // External 32-bit ALU
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum      = '0;
    alu_out      = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_aluc)
      4'b0000: alu_out = alu_ina;
      4'b0010: alu_out = ~alu_ina;
      4'b0011: alu_out = ~alu_inb;
      4'b0100, 4'b0101: begin
        alu_sum = {1'b0, alu_ina} + {1'b0, alu_inb} +
                  ((alu_aluc == 4'b0101) ? {32'd0, alu_cin} : 33'd0);
        alu_out      = alu_sum[31:0];
        alu_cout     = alu_sum[32];
        alu_overflow = (alu_ina[31] == alu_inb[31]) && (alu_sum[31] != alu_ina[31]);
      end
      4'b0110: alu_out = alu_ina | alu_inb;
      4'b0111: alu_out = alu_ina & alu_inb;
      default: alu_out = '0;
    endcase
  end

  task automatic ref_model(input logic [2:0] o, input logic [63:0] a, b, input logic ci,
                           input logic [63:0] prev, output logic [63:0] r,
                           output logic cy, ov, er, output int lat);
    logic [64:0] s;
    logic [63:0] bb;
    s = '0; bb = b; cy = 0; ov = 0; er = 0; lat = 3; r = prev;
    case (o)
      3'd0, 3'd1, 3'd2: begin
        bb = (o == 3'd2) ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + ((o == 3'd1) ? {64'd0, ci} : (o == 3'd2) ? 65'd1 : 65'd0);
        r  = s[63:0];
        cy = s[64];
        ov = (a[63] == bb[63]) && (s[63] != a[63]);
        if (o == 3'd2) lat = 5;
      end
      3'd3: r = a | b;
      3'd4: r = a & b;
      3'd5: r = ~a;
      3'd6: r = a;
      default: begin er = 1; lat = 1; end
    endcase
  endtask

  task automatic do_op(input logic [2:0] o, input logic [63:0] a, b, input logic ci,
                       output int lat, output logic [63:0] r, output logic cy, ov, er);
    @(negedge clk);
    op = o; opa = a; opb = b; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat <= 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat > 20) lat = -1;
    r = result; cy = carry; ov = ovf; er = err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, carry, ovf, err, alu_cin} !== 6'b0 || result !== 64'd0 ||
        alu_ina !== 32'd0 || alu_inb !== 32'd0 || alu_aluc !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b c=%b v=%b e=%b res=%h ina=%h inb=%h aluc=%b cin=%b required all zero, aluc=1000",
               busy, done, carry, ovf, err, result, alu_ina, alu_inb, alu_aluc, alu_cin);
    end
    reset = 1'b0;
    last_res = '0;
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [63:0] a, b;
    logic        ci;
    logic [63:0] r;
    logic        cy, ov;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[8];
    int lat;
    logic [63:0] r;
    logic cy, ov, er;
    v[0] = '{3'd0, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 64'h00000001_00000000, 1'b0, 1'b0, 3};
    v[1] = '{3'd2, 64'h0, 64'h1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 5};
    v[2] = '{3'd0, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 64'h80000000_00000000, 1'b0, 1'b1, 3};
    v[3] = '{3'd1, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, 3};
    v[4] = '{3'd3, 64'hF0F0F0F0_0F0F0F0F, 64'hFF00FF00_00FF00FF, 1'b1, 64'hFFF0FFF0_0FFF0FFF, 1'b0, 1'b0, 3};
    v[5] = '{3'd4, 64'hF0F0F0F0_0F0F0F0F, 64'hFF00FF00_00FF00FF, 1'b1, 64'hF000F000_000F000F, 1'b0, 1'b0, 3};
    v[6] = '{3'd5, 64'hF0F0F0F0_0F0F0F0F, 64'hFF00FF00_00FF00FF, 1'b1, 64'h0F0F0F0F_F0F0F0F0, 1'b0, 1'b0, 3};
    v[7] = '{3'd6, 64'hF0F0F0F0_0F0F0F0F, 64'hFF00FF00_00FF00FF, 1'b1, 64'hF0F0F0F0_0F0F0F0F, 1'b0, 1'b0, 3};
    for (int i = 0; i < 8; i++) begin
      do_op(v[i].o, v[i].a, v[i].b, v[i].ci, lat, r, cy, ov, er);
      checks++;
      if (r !== v[i].r || cy !== v[i].cy || ov !== v[i].ov || er !== 1'b0 || lat != v[i].lat) begin
        errors++;
        $display("FAIL directed[%0d] res=%h c=%b v=%b e=%b lat=%0d required res=%h c=%b v=%b e=0 lat=%0d",
                 i, r, cy, ov, er, lat, v[i].r, v[i].cy, v[i].ov, v[i].lat);
      end
      last_res = v[i].r;
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int extra;
    @(negedge clk);
    op = 3'd0; opa = 64'd5; opb = 64'd7; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    op = 3'd2; opa = 64'h1234; opb = 64'h9999_0000_0000; cin = 1'b1;
    lat = 1;
    while (done !== 1'b1 && lat <= 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 3 || result !== 64'd12 || carry !== 1'b0) begin
      errors++;
      $display("FAIL busy_first_op lat=%0d res=%h c=%b required lat=3 res=000000000000000c c=0",
               lat, result, carry);
    end
    last_res = 64'd12;
    @(posedge clk); #1;
    start = 1'b0;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || result !== 64'd12) begin
      errors++;
      $display("FAIL busy_start_ignored active_cycles=%0d res=%h required 0 and res=000000000000000c",
               extra, result);
    end
  endtask

  task automatic test_reserved();
    int lat;
    logic [63:0] r;
    logic cy, ov, er;
    do_op(3'd1, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b1, lat, r, cy, ov, er);
    last_res = r;
    checks++;
    if (cy !== 1'b1) begin
      errors++;
      $display("FAIL rsv_setup_carry c=%b required 1", cy);
    end
    do_op(3'd1, 64'h0000_0000_0000_00AA, 64'h0000_0000_0000_0011, 1'b0, lat, r, cy, ov, er);
    last_res = 64'hBB;
    do_op(3'd0, 64'hFFFFFFFF_FFFFFFFF, 64'h2, 1'b0, lat, r, cy, ov, er);
    last_res = 64'h1;
    do_op(3'd7, 64'h1111, 64'h2222, 1'b1, lat, r, cy, ov, er);
    checks++;
    if (er !== 1'b1 || lat != 1 || r !== last_res || cy !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL reserved_op e=%b lat=%0d res=%h c=%b v=%b required e=1 lat=1 res=%h c=0 v=0",
               er, lat, r, cy, ov, last_res);
    end
    do_op(3'd0, 64'd3, 64'd4, 1'b0, lat, r, cy, ov, er);
    last_res = r;
    checks++;
    if (er !== 1'b0 || r !== 64'd7) begin
      errors++;
      $display("FAIL err_cleared e=%b res=%h required e=0 res=0000000000000007", er, r);
    end
  endtask

  task automatic test_random();
    int lat, exp_lat;
    logic [63:0] r, a, b, exp_r;
    logic cy, ov, er, exp_cy, exp_ov, exp_er, ci;
    logic [2:0] o;
    for (int i = 0; i < 60; i++) begin
      o  = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      ci = 1'($urandom_range(0, 1));
      if (i % 5 == 0) a = {32'h7FFFFFFF, $urandom};
      if (i % 7 == 0) b = 64'hFFFFFFFF_FFFFFFFF;
      ref_model(o, a, b, ci, last_res, exp_r, exp_cy, exp_ov, exp_er, exp_lat);
      do_op(o, a, b, ci, lat, r, cy, ov, er);
      checks++;
      if (r !== exp_r || cy !== exp_cy || ov !== exp_ov || er !== exp_er || lat != exp_lat) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h ci=%b got res=%h c=%b v=%b e=%b lat=%0d required res=%h c=%b v=%b e=%b lat=%0d",
                 i, o, a, b, ci, r, cy, ov, er, lat, exp_r, exp_cy, exp_ov, exp_er, exp_lat);
      end
      last_res = exp_r;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] r;
    logic cy, ov, er;
    do_op(3'd2, 64'd100, 64'd58, 1'b0, lat, r, cy, ov, er);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%b done=%b required 0 0", busy, done);
    end
    do_op(3'd2, 64'd5, 64'd9, 1'b0, lat, r, cy, ov, er);
    checks++;
    if (r !== 64'hFFFFFFFF_FFFFFFFC || cy !== 1'b0 || lat != 5) begin
      errors++;
      $display("FAIL b2b_second res=%h c=%b lat=%0d required res=fffffffffffffffc c=0 lat=5", r, cy, lat);
    end
    last_res = r;
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    op = 3'd0; opa = 64'h0000_0001_FFFF_FFFF; opb = 64'h1; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, carry, ovf, err, alu_cin} !== 6'b0 || result !== 64'd0 ||
        alu_ina !== 32'd0 || alu_inb !== 32'd0 || alu_aluc !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b c=%b v=%b e=%b res=%h ina=%h inb=%h aluc=%b cin=%b required reset values",
               busy, done, carry, ovf, err, result, alu_ina, alu_inb, alu_aluc, alu_cin);
    end
    reset = 1'b0;
    last_res = '0;
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || result !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_no_done active_cycles=%0d res=%h required 0 and res=0", pulses, result);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reserved();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
